// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one tagged memory port among the I-cache (0), the D-cache (1) and the
// evict path (2). Requests are granted round-robin and issued as a registered query that is
// held until memory accepts it. Each accepted load tag records its owner so that the memory
// answer can be routed back by tag.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_cmd/addr/data     per-requester command (NONE/LOAD/STORE), block address, store data
//   req_ack               per-requester accept tag, nonzero for the single accept cycle
//   rsp_tag, rsp_blk      per-requester answer tag (owner only), broadcast answer data
//   mem_qry_cmd/addr/data registered memory query
//   mem_ack               memory accept tag for the current query (0 = not accepted)
//   mem_ans_tag/blk       memory answer tag (0 = none) and data
//   busy                  a query is pending or some load tag is outstanding
//   err                   one-cycle pulse after a stray answer or a reused load tag
module mem_arbiter #(
   parameter int unsigned N      = 3,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BLK_W  = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N-1:0][1:0]            req_cmd,
   input  logic [N-1:0][ADDR_W-1:0]     req_addr,
   input  logic [N-1:0][BLK_W-1:0]      req_data,
   output logic [N-1:0][TAG_W-1:0]      req_ack,
   output logic [N-1:0][TAG_W-1:0]      rsp_tag,
   output logic [BLK_W-1:0]             rsp_blk,
   output logic [1:0]                   mem_qry_cmd,
   output logic [ADDR_W-1:0]            mem_qry_addr,
   output logic [BLK_W-1:0]             mem_qry_data,
   input  logic [TAG_W-1:0]             mem_ack,
   input  logic [TAG_W-1:0]             mem_ans_tag,
   input  logic [BLK_W-1:0]             mem_ans_blk,
   output logic                         busy,
   output logic                         err
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DEPTH = 1 << TAG_W;

   localparam logic [1:0] CmdNone  = 2'd0;
   localparam logic [1:0] CmdLoad  = 2'd1;

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   grant_q;
   logic [IDX_W-1:0]   ptr_q;
   logic               err_q;
   logic [DEPTH-1:0]   own_vld_q;
   logic [IDX_W-1:0]   own_idx_q [DEPTH];

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   cand;
   logic               ack_fire;
   logic               load_ack;
   logic               ans_hit;
   logic               stray;
   logic               reuse;

   // First active requester at or after ptr_q, wrapping modulo N.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % N);
         if (!pick_vld && req_cmd[cand] != CmdNone) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign ack_fire = (state_q == StIssue) && (mem_ack != '0);
   assign load_ack = ack_fire && (mem_qry_cmd == CmdLoad);
   assign ans_hit  = (mem_ans_tag != '0) && own_vld_q[mem_ans_tag];
   assign stray    = (mem_ans_tag != '0) && !own_vld_q[mem_ans_tag];
   // An answer on the same tag frees the entry in this cycle, so that ack is not a reuse.
   assign reuse    = load_ack && own_vld_q[mem_ack] && !(ans_hit && (mem_ans_tag == mem_ack));

   always_comb begin
      req_ack = '0;
      if (ack_fire) req_ack[grant_q] = mem_ack;
   end

   always_comb begin
      rsp_tag = '0;
      if (ans_hit) rsp_tag[own_idx_q[mem_ans_tag]] = mem_ans_tag;
   end

   assign rsp_blk = mem_ans_blk;
   assign busy    = (state_q == StIssue) || (|own_vld_q);
   assign err     = err_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         ptr_q        <= '0;
         err_q        <= 1'b0;
         mem_qry_cmd  <= CmdNone;
         mem_qry_addr <= '0;
         mem_qry_data <= '0;
         own_vld_q    <= '0;
         for (int unsigned t = 0; t < DEPTH; t++) own_idx_q[t] <= '0;
      end else begin
         err_q <= stray || reuse;
         if (ans_hit) own_vld_q[mem_ans_tag] <= 1'b0;
         case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  mem_qry_cmd  <= req_cmd[pick_idx];
                  mem_qry_addr <= req_addr[pick_idx];
                  mem_qry_data <= req_data[pick_idx];
                  grant_q      <= pick_idx;
                  state_q      <= StIssue;
               end
            end
            StIssue: begin
               if (ack_fire) begin
                  // Later assignment wins over the answer-side clear on a same-tag collision.
                  if (load_ack) begin
                     own_vld_q[mem_ack] <= 1'b1;
                     own_idx_q[mem_ack] <= grant_q;
                  end
                  mem_qry_cmd <= CmdNone;
                  ptr_q       <= (grant_q == IDX_W'(N - 1)) ? '0 : grant_q + 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam logic [1:0] CN = 2'd0;
   localparam logic [1:0] CL = 2'd1;
   localparam logic [1:0] CS = 2'd2;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] C0L  = 6'b000001;
   localparam logic [5:0] C1L  = 6'b000100;
   localparam logic [5:0] C2L  = 6'b010000;
   localparam logic [5:0] C2S  = 6'b100000;
   localparam logic [5:0] C12L = 6'b010100;
   localparam logic [5:0] ALL  = 6'b010101;

   localparam logic [31:0] A0 = 32'h0;
   localparam logic [31:0] A1 = 32'h40;
   localparam logic [31:0] A2 = 32'h8;
   localparam logic [63:0] D0 = 64'h0000_0000_0000_1111;
   localparam logic [63:0] D1 = 64'h0000_0000_0000_2222;
   localparam logic [63:0] D2 = 64'h1234_5678_ffff_ffff;
   localparam logic [63:0] BLK = 64'hdead_beef_cc00_ffee;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [2:0][1:0]   req_cmd = '0;
   logic [2:0][31:0]  req_addr;
   logic [2:0][63:0]  req_data;
   logic [2:0][3:0]   req_ack;
   logic [2:0][3:0]   rsp_tag;
   logic [63:0]       rsp_blk;
   logic [1:0]        mem_qry_cmd;
   logic [31:0]       mem_qry_addr;
   logic [63:0]       mem_qry_data;
   logic [3:0]        mem_ack = '0;
   logic [3:0]        mem_ans_tag = '0;
   logic [63:0]       mem_ans_blk = '0;
   logic              busy;
   logic              err;

   assign req_addr = {A2, A1, A0};
   assign req_data = {D2, D1, D0};

   always #5 clock = ~clock;

   mem_arbiter #(.N(3), .TAG_W(4), .ADDR_W(32), .BLK_W(64)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_cmd      (req_cmd),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_ack      (req_ack),
      .rsp_tag      (rsp_tag),
      .rsp_blk      (rsp_blk),
      .mem_qry_cmd  (mem_qry_cmd),
      .mem_qry_addr (mem_qry_addr),
      .mem_qry_data (mem_qry_data),
      .mem_ack      (mem_ack),
      .mem_ans_tag  (mem_ans_tag),
      .mem_ans_blk  (mem_ans_blk),
      .busy         (busy),
      .err          (err)
   );

   // One record per clock cycle: inputs for the cycle and outputs expected before its edge.
   // qsel picks the requester whose addr/data should sit in the query registers (3 = zeros);
   // err = 2 means the err output is not checked for that cycle.
   typedef struct {
      logic        rst;
      logic [5:0]  cmd;
      logic [3:0]  ack;
      logic [3:0]  ans;
      logic [1:0]  qcmd;
      int          qsel;
      logic [11:0] rack;
      logic [11:0] rtag;
      logic        busy;
      logic [1:0]  err;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   passed = 0;

   function automatic vec_t mk(input logic r, input logic [5:0] c, input logic [3:0] a,
                               input logic [3:0] s, input logic [1:0] qc, input int qs,
                               input logic [11:0] ra, input logic [11:0] rt, input logic b,
                               input logic [1:0] e);
      vec_t v;
      v.rst = r; v.cmd = c; v.ack = a; v.ans = s; v.qcmd = qc; v.qsel = qs;
      v.rack = ra; v.rtag = rt; v.busy = b; v.err = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [187:0] act, input logic [187:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic step(input logic [5:0] c, input logic [3:0] a, input logic [3:0] s);
      @(negedge clock);
      req_cmd     = c;
      mem_ack     = a;
      mem_ans_tag = s;
      mem_ans_blk = BLK;
      #1;
   endtask

   initial begin
      logic [31:0]  ea;
      logic [63:0]  ed;
      logic         eerr;
      logic [187:0] act;
      logic [187:0] exp;

      //             rst cmd  ack ans qcmd qsel rack     rtag     busy err
      // single load, delayed ack
      vecs.push_back(mk(1, NONE, 0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, C0L,  0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, C0L,  0, 0, CL, 0, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C0L,  0, 0, CL, 0, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C0L,  1, 0, CL, 0, 12'h001, 12'h000, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 0, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 1, CN, 0, 12'h000, 12'h001, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 0, 12'h000, 12'h000, 0, 0));
      // round-robin from a fresh reset
      vecs.push_back(mk(1, NONE, 0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, ALL,  0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, ALL,  1, 0, CL, 0, 12'h001, 12'h000, 1, 0));
      vecs.push_back(mk(0, C12L, 0, 0, CN, 0, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C12L, 2, 0, CL, 1, 12'h020, 12'h000, 1, 0));
      vecs.push_back(mk(0, C2L,  0, 0, CN, 1, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C2L,  3, 0, CL, 2, 12'h300, 12'h000, 1, 0));
      vecs.push_back(mk(0, ALL,  0, 0, CN, 2, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, ALL,  0, 0, CL, 0, 12'h000, 12'h000, 1, 0));
      // reset while waiting for ack; old tag answer afterwards is stray
      vecs.push_back(mk(1, ALL,  0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, NONE, 0, 2, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 3, 12'h000, 12'h000, 0, 1));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      // evict store: no table entry, answer on its tag is stray
      vecs.push_back(mk(0, C2S,  0, 0, CN, 3, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, C2S,  5, 0, CS, 2, 12'h500, 12'h000, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 2, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, NONE, 0, 5, CN, 2, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 2, 12'h000, 12'h000, 0, 1));
      // out-of-order answers
      vecs.push_back(mk(0, C1L,  0, 0, CN, 2, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, C1L,  2, 0, CL, 1, 12'h020, 12'h000, 1, 0));
      vecs.push_back(mk(0, C0L,  0, 0, CN, 1, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C0L,  3, 0, CL, 0, 12'h003, 12'h000, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 3, CN, 0, 12'h000, 12'h003, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 2, CN, 0, 12'h000, 12'h020, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 0, 12'h000, 12'h000, 0, 0));
      // same-tag ack/answer collision; ptr=1 so the lone I-cache request wraps to 0
      vecs.push_back(mk(0, C0L,  0, 0, CN, 0, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, C0L,  4, 0, CL, 0, 12'h004, 12'h000, 1, 0));
      vecs.push_back(mk(0, C1L,  0, 0, CN, 0, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C1L,  4, 4, CL, 1, 12'h040, 12'h004, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 1, 12'h000, 12'h000, 1, 2));
      vecs.push_back(mk(0, NONE, 0, 4, CN, 1, 12'h000, 12'h040, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 1, 12'h000, 12'h000, 0, 0));
      // tag reuse: second ack on a live tag overwrites the owner and pulses err
      vecs.push_back(mk(0, C2L,  0, 0, CN, 1, 12'h000, 12'h000, 0, 0));
      vecs.push_back(mk(0, C2L,  6, 0, CL, 2, 12'h600, 12'h000, 1, 0));
      vecs.push_back(mk(0, C0L,  0, 0, CN, 2, 12'h000, 12'h000, 1, 0));
      vecs.push_back(mk(0, C0L,  6, 0, CL, 0, 12'h006, 12'h000, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 0, 12'h000, 12'h000, 1, 1));
      vecs.push_back(mk(0, NONE, 0, 6, CN, 0, 12'h000, 12'h006, 1, 0));
      vecs.push_back(mk(0, NONE, 0, 0, CN, 0, 12'h000, 12'h000, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         reset       = ~vecs[i].rst;
         req_cmd     = vecs[i].cmd;
         mem_ack     = vecs[i].ack;
         mem_ans_tag = vecs[i].ans;
         mem_ans_blk = BLK;
         #1;
         case (vecs[i].qsel)
            0:       begin ea = A0; ed = D0; end
            1:       begin ea = A1; ed = D1; end
            2:       begin ea = A2; ed = D2; end
            default: begin ea = '0; ed = '0; end
         endcase
         eerr = (vecs[i].err == 2'd2) ? err : vecs[i].err[0];
         act = {mem_qry_cmd, mem_qry_addr, mem_qry_data, req_ack, rsp_tag, busy, err, rsp_blk};
         exp = {vecs[i].qcmd, ea, ed, vecs[i].rack, vecs[i].rtag, vecs[i].busy, eerr, BLK};
         check($sformatf("vec%0d", i), act, exp);
      end

      // Query held for a long time with no ack; ptr is 1 here, so the D-cache wins.
      step(C1L, 0, 0);
      for (int c = 0; c < 20; c++) begin
         step(C1L, 0, 0);
         check($sformatf("hold%0d", c), {mem_qry_cmd, mem_qry_addr, req_ack, busy},
               {CL, A1, 12'h000, 1'b1});
      end
      step(C1L, 7, 0);
      check("late_ack", req_ack, 12'h070);
      step(NONE, 0, 0);
      check("after_ack", {mem_qry_cmd, busy, err}, {CN, 1'b1, 1'b0});
      step(NONE, 0, 7);
      check("late_rsp", rsp_tag, 12'h070);
      step(NONE, 0, 0);
      check("drain", {busy, err, rsp_tag}, {1'b0, 1'b0, 12'h000});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
